// File: rtl/serializador.sv
`default_nettype none
// ============================================================================
//  Module   : serializador
//  Purpose  : Parallel-to-serial byte transmitter. Accepts a byte over a
//             valid/ready handshake, shifts it out MSB-first framed by
//             write_out for DATA_W clocks, then waits for ack_in, giving up
//             with a one-cycle error_out pulse after ACK_TIMEOUT cycles
//             (ACK_TIMEOUT = 0 waits forever).
//  Ports    : clock_100KHz   - single clock, rising edge
//             reset          - synchronous, active-high
//             data_in/valid_in/ready_out - upstream byte handshake
//             data_out/write_out         - serial bit and frame strobe
//             ack_in         - receiver consumed the byte
//             busy_out       - frame or acknowledge wait in progress
//             error_out      - one-cycle pulse on acknowledge timeout
//             sent_count_out - acknowledged bytes, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module serializador #(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clock_100KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              write_out,
    input  logic              ack_in,
    output logic              busy_out,
    output logic              error_out,
    output logic [7:0]        sent_count_out
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  c_bit_last  = CNT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic              c_to_en     = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                ready_q;
    logic                write_q;
    logic                busy_q;
    logic                error_q;
    logic [7:0]          count_q;

    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ready_q    <= 1'b1;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            // error_out is a single-cycle pulse unless re-armed below
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        shreg_q   <= data_in;
                        bit_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        write_q   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == c_bit_last) begin
                        state_q    <= ST_WAIT_ACK;
                        wait_cnt_q <= '0;
                        write_q    <= 1'b0;
                    end else begin
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // ack has priority over a timeout on the same edge
                    if (ack_in) begin
                        state_q <= ST_IDLE;
                        count_q <= count_q + 8'd1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (c_to_en && (wait_cnt_q == c_wait_last)) begin
                        state_q <= ST_IDLE;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (c_to_en) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    // Serial bit is the register MSB, gated by the registered frame strobe so
    // the line rests at 0 outside a frame.
    assign data_out       = write_q & shreg_q[DATA_W-1];
    assign ready_out      = ready_q;
    assign write_out      = write_q;
    assign busy_out       = busy_q;
    assign error_out      = error_q;
    assign sent_count_out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_serializador.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serializador
//  Purpose  : Self-checking bench for serializador (DATA_W=8, ACK_TIMEOUT=4).
//             A cycle-level reference model tracks elapsed cycles since each
//             accept; a negedge process compares every output every cycle,
//             and directed sequences pin literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serializador;

    localparam int DATA_W = 8;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              write_out;
    logic              ack_in;
    logic              busy_out;
    logic              error_out;
    logic [7:0]        sent_count_out;

    serializador #(.DATA_W(DATA_W), .ACK_TIMEOUT(TO)) dut (
        .clock_100KHz   (clk),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .write_out      (write_out),
        .ack_in         (ack_in),
        .busy_out       (busy_out),
        .error_out      (error_out),
        .sent_count_out (sent_count_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: m_k = cycles since accept (-1 when idle).
    // 0..DATA_W-1 -> transmitting bit DATA_W-1-m_k; >= DATA_W -> waiting for
    // ack, having waited m_k-DATA_W cycles so far.
    int               m_k     = -1;
    logic [DATA_W-1:0] m_byte = '0;
    int               m_count = 0;
    bit               m_err   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_k     <= -1;
            m_count <= 0;
            m_err   <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_k < 0) begin
                if (valid_in) begin
                    m_byte <= data_in;
                    m_k    <= 0;
                end
            end else if (m_k < DATA_W) begin
                m_k <= m_k + 1;
            end else if (ack_in) begin
                m_k     <= -1;
                m_count <= (m_count + 1) % 256;
            end else if (TO != 0 && (m_k - DATA_W) == TO - 1) begin
                m_k   <= -1;
                m_err <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_w;
            logic exp_d;
            exp_w = (m_k >= 0 && m_k < DATA_W);
            exp_d = exp_w ? m_byte[DATA_W-1-m_k] : 1'b0;
            check("cyc_write", 32'(write_out), 32'(exp_w));
            check("cyc_data", 32'(data_out), 32'(exp_d));
            check("cyc_ready", 32'(ready_out), 32'(m_k < 0));
            check("cyc_busy", 32'(busy_out), 32'(m_k >= 0));
            check("cyc_error", 32'(error_out), 32'(m_err));
            check("cyc_count", 32'(sent_count_out), 32'(m_count));
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Accept one byte, then sample the 8 frame cycles; returns after the edge
    // that ends the frame.
    task automatic send_collect(input logic [7:0] b, output logic [7:0] got, output int wcount);
        valid_in = 1'b1;
        data_in  = b;
        step();
        valid_in = 1'b0;
        got      = '0;
        wcount   = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (write_out) wcount++;
            got = {got[6:0], data_out};
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g;
        int         w;
        int         waitc;
        int         errc;
        logic [7:0] bb [3];
        logic [7:0] gotb [3];
        int         starts [3];
        int         started;
        int         nbits;
        logic [7:0] cur;
        logic       prev_w;

        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        ack_in   = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_write", 32'(write_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_error", 32'(error_out), 32'd0);
        check("rst_count", 32'(sent_count_out), 32'd0);
        reset = 1'b0;
        step();

        // 0xA5 frame, ack on the third WAIT_ACK cycle
        send_collect(8'hA5, g, w);
        check("a5_bits", 32'(g), 32'hA5);
        check("a5_wcnt", 32'(w), 32'd8);
        check("a5_write_fall", 32'(write_out), 32'd0);
        check("a5_busy_wait", 32'(busy_out), 32'd1);
        check("a5_ready_wait", 32'(ready_out), 32'd0);
        step();
        step();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        check("a5_ready_after", 32'(ready_out), 32'd1);
        check("a5_count", 32'(sent_count_out), 32'd1);
        check("a5_error", 32'(error_out), 32'd0);
        step();

        // 0x3C with no ack: 4 wait cycles then one error pulse
        send_collect(8'h3C, g, w);
        check("3c_bits", 32'(g), 32'h3C);
        waitc = 0;
        errc  = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_out && !write_out) waitc++;
            if (error_out) errc++;
            step();
        end
        check("to_wait_cycles", 32'(waitc), 32'd4);
        check("to_error_pulses", 32'(errc), 32'd1);
        check("to_count", 32'(sent_count_out), 32'd1);
        check("to_ready", 32'(ready_out), 32'd1);

        // ack on the very edge the timeout would fire
        send_collect(8'h96, g, w);
        step();
        step();
        step();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        check("tie_error", 32'(error_out), 32'd0);
        check("tie_count", 32'(sent_count_out), 32'd2);
        check("tie_ready", 32'(ready_out), 32'd1);
        step();
        check("tie_error_late", 32'(error_out), 32'd0);

        // back-to-back with ack held high, data_in scrambled during frames
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("b2b_count_rst", 32'(sent_count_out), 32'd0);
        bb[0] = 8'h01;
        bb[1] = 8'h80;
        bb[2] = 8'hFF;
        gotb[0] = '0;
        gotb[1] = '0;
        gotb[2] = '0;
        starts[0] = 0;
        starts[1] = 0;
        starts[2] = 0;
        started = 0;
        nbits   = 0;
        cur     = '0;
        prev_w  = 1'b0;
        ack_in   = 1'b1;
        valid_in = 1'b1;
        data_in  = bb[0];
        for (int i = 0; i < 40; i++) begin
            step();
            if (write_out) begin
                if (!prev_w && started < 3) begin
                    starts[started] = cyc;
                    started++;
                    nbits = 0;
                end
                cur = {cur[6:0], data_out};
                nbits++;
                if (nbits == 8 && started > 0) gotb[started-1] = cur;
            end
            prev_w = write_out;
            if (ready_out) begin
                if (started < 3) begin
                    data_in  = bb[started];
                    valid_in = 1'b1;
                end else begin
                    valid_in = 1'b0;
                end
            end else begin
                data_in = 8'($urandom);
            end
        end
        ack_in   = 1'b0;
        valid_in = 1'b0;
        check("b2b_frames", 32'(started), 32'd3);
        check("b2b_byte0", 32'(gotb[0]), 32'h01);
        check("b2b_byte1", 32'(gotb[1]), 32'h80);
        check("b2b_byte2", 32'(gotb[2]), 32'hFF);
        check("b2b_gap01", 32'(starts[1] - starts[0]), 32'd10);
        check("b2b_gap12", 32'(starts[2] - starts[1]), 32'd10);
        check("b2b_count", 32'(sent_count_out), 32'd3);

        // reset in the middle of a 0xF0 frame, then a clean 0x55 frame
        valid_in = 1'b1;
        data_in  = 8'hF0;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_write_before", 32'(write_out), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_write", 32'(write_out), 32'd0);
        check("mid_data", 32'(data_out), 32'd0);
        check("mid_ready", 32'(ready_out), 32'd1);
        check("mid_busy", 32'(busy_out), 32'd0);
        check("mid_count", 32'(sent_count_out), 32'd0);
        send_collect(8'h55, g, w);
        check("55_bits", 32'(g), 32'h55);
        check("55_wcnt", 32'(w), 32'd8);
        check("55_write_fall", 32'(write_out), 32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serializador.md
Name: serializador

Overview:
- Transmit-side counterpart of the byte deserializer. Takes parallel bytes from an upstream source (normally the queue's data_out / dequeue side) over a valid/ready handshake.
- Shifts each byte out MSB-first on data_out. write_out frames the transfer for exactly 8 clocks.
- After each byte, waits for an acknowledge from the receiving end before taking the next byte, with an optional timeout.
- Runs in the 100 kHz domain generated by the top level.

Parameters:
- DATA_W, 8, byte width in bits; bit counter sized to hold DATA_W-1.
- ACK_TIMEOUT, 16, maximum WAIT_ACK cycles before giving up; 0 = wait forever.

Ports:
- clock_100KHz  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_W  byte to send; sampled only on accept.
- valid_in  in  1  upstream has a byte on data_in.
- ready_out  out  1  block can accept a byte this cycle.
- data_out  out  1  serial bit, MSB first.
- write_out  out  1  high while a frame bit is on data_out.
- ack_in  in  1  receiver has consumed the byte.
- busy_out  out  1  high in SHIFT or WAIT_ACK.
- error_out  out  1  one-cycle pulse on ack timeout.
- sent_count_out  out  8  count of acknowledged bytes, wraps 255->0.

Behaviour:
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset (sampled at an edge) forces:
  - state=IDLE, ready_out=1, data_out=0, write_out=0, busy_out=0, error_out=0, sent_count_out=0.
  - Shift register, bit counter and wait counter cleared.
  - A frame in progress is aborted immediately; write_out is low the cycle after the reset edge, with no partial-byte completion.
- State IDLE:
  - ready_out=1, busy_out=0, write_out=0, data_out=0.
  - An edge with valid_in=1 is an accept: capture data_in, bit_cnt=0, go to SHIFT.
- State SHIFT:
  - ready_out=0, busy_out=1, write_out=1, data_out=shreg[DATA_W-1].
  - Each edge: if bit_cnt==DATA_W-1, go to WAIT_ACK with wait_cnt=0; otherwise shift left by one and increment bit_cnt.
  - Timing: accept at edge N gives write_out=1 after edges N through N+DATA_W-1, carrying bits 7..0 in that order. write_out falls after edge N+DATA_W.
- State WAIT_ACK:
  - ready_out=0, busy_out=1, write_out=0, data_out=0.
  - At each edge, evaluated in priority order:
    1. ack_in=1: go to IDLE and increment sent_count_out.
    2. ACK_TIMEOUT!=0 and wait_cnt==ACK_TIMEOUT-1: go to IDLE, error_out=1 for exactly one cycle, byte dropped, sent_count_out unchanged.
    3. Otherwise increment wait_cnt.
  - ack_in on the same edge as the timeout wins; no error is flagged.
- ack_in is ignored in IDLE and SHIFT; an early or stuck-high ack_in does not count until WAIT_ACK.
- valid_in and data_in are ignored while ready_out=0. Upstream holds valid_in until it sees ready_out=1 on an edge.
- Back-to-back throughput: with ack in the first WAIT_ACK cycle, a byte takes DATA_W+2 cycles (SHIFT 8, WAIT_ACK 1, IDLE 1).
- sent_count_out is 8-bit modulo, independent of DATA_W.
- ACK_TIMEOUT=0: no timeout; error_out is never asserted.

Test Plan:
- Reset, then valid_in=1 with data_in=0xA5 for one edge -> ready_out drops; write_out high 8 cycles; data_out = 1,0,1,0,0,1,0,1; then write_out=0, busy_out=1.
- Same frame, ack_in pulsed 3 cycles into WAIT_ACK -> IDLE on that edge, sent_count_out 0->1, error_out stays 0, ready_out=1 next cycle.
- ACK_TIMEOUT=4, send 0x3C, never ack -> exactly 4 WAIT_ACK cycles, then one-cycle error_out pulse, state IDLE, sent_count_out unchanged.
- ACK_TIMEOUT=4, ack_in on the same edge as the timeout -> no error, sent_count_out increments.
- Hold ack_in=1 throughout, send 0x01, 0x80, 0xFF back-to-back with valid_in held -> frames 10 cycles apart, bits match MSB-first, sent_count_out=3. Change data_in during SHIFT and confirm it is ignored.
- Assert reset at bit 4 of a 0xF0 frame -> next cycle write_out=0, data_out=0, ready_out=1, sent_count_out=0. Then send 0x55 -> clean frame 0,1,0,1,0,1,0,1.
